// File: rtl/vu_pkg.sv
// vu_pkg: shared types and helpers for the spectrum / level-meter display path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vu_pkg;

   // Frame-drain controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      GAP    = 2'd2,
      UPDATE = 2'd3
   } state_t;

   // One extra bit above the component width holds max + min/2 without overflow.
   function automatic int mag_width(input int width);
      return width + 1;
   endfunction

   // Positive-frequency bins (1..samples/2) split evenly over the bands.
   function automatic int bins_per_band(input int samples, input int bands);
      return samples / (2 * bands);
   endfunction

   // Band for bin k; only meaningful for 1 <= k <= samples/2.
   function automatic int band_index(input int bin, input int bpb);
      return (bin - 1) / bpb;
   endfunction

endpackage

// File: rtl/cplx_mag.sv
// cplx_mag: alpha-max-plus-beta-min magnitude estimate, |z| ~ max(|re|,|im|) + min(|re|,|im|)/2.
// Latency: combinational, no registers.
// Backpressure: none; output follows inputs.
// Ports: re, im (signed WIDTH) in; mag (unsigned WIDTH+1) out.
module cplx_mag
   import vu_pkg::*;
#(
   parameter int  WIDTH = 8,
   localparam int MAG_W = mag_width(WIDTH)
) (
   input  logic [WIDTH-1:0] re,
   input  logic [WIDTH-1:0] im,
   output logic [MAG_W-1:0] mag
);

   logic [WIDTH-1:0] abs_re;
   logic [WIDTH-1:0] abs_im;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   always_comb begin
      // Negating the most negative value wraps to 2^(WIDTH-1), which is the
      // correct magnitude when read back as unsigned.
      abs_re = re[WIDTH-1] ? -re : re;
      abs_im = im[WIDTH-1] ? -im : im;
      hi     = (abs_re > abs_im) ? abs_re : abs_im;
      lo     = (abs_re > abs_im) ? abs_im : abs_re;
      mag    = {1'b0, hi} + MAG_W'(lo >> 1);
   end

endmodule

// File: rtl/spectrum_bands.sv
// spectrum_bands: drains one FFT frame, folds positive bins into peak-per-band levels with decay.
// Latency: 2*SAMPLES-1 cycles from first READ to UPDATE; o_valid/o_levels register on the edge leaving the last READ.
// Backpressure: none; paces the source with one strobe every 2 cycles, abandons the frame if the source runs empty.
// Ports: i_clk, i_rst_n; source bin re/im + full/empty in, o_source_strobe out; o_levels/o_valid/o_busy to display.
module spectrum_bands
   import vu_pkg::*;
#(
   parameter int  WIDTH   = 8,
   parameter int  SAMPLES = 128,
   parameter int  BANDS   = 8,
   parameter int  DECAY   = 4,
   localparam int MAG_W   = mag_width(WIDTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [WIDTH-1:0]       i_source_real,
   input  logic [WIDTH-1:0]       i_source_cplx,
   input  logic                   i_source_full,
   input  logic                   i_source_empty,
   output logic                   o_source_strobe,
   output logic [BANDS*MAG_W-1:0] o_levels,
   output logic                   o_valid,
   output logic                   o_busy
);

   localparam int BPB   = bins_per_band(SAMPLES, BANDS);
   localparam int IDX_W = $clog2(SAMPLES);
   localparam int LAST  = SAMPLES - 1;
   localparam int HALF  = SAMPLES / 2;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [MAG_W-1:0] mag;
   logic             last_bin;
   logic             in_range;
   int               band_sel;

   logic [MAG_W-1:0] peak      [BANDS];
   logic [MAG_W-1:0] peak_nxt  [BANDS];
   logic [MAG_W-1:0] decayed   [BANDS];
   logic [MAG_W-1:0] level_new [BANDS];

   cplx_mag #(.WIDTH(WIDTH)) u_mag (
      .re  (i_source_real),
      .im  (i_source_cplx),
      .mag (mag)
   );

   assign last_bin = (int'(idx) == LAST);
   // DC (bin 0) and the mirrored upper half are read but never accumulated.
   assign in_range = (int'(idx) >= 1) && (int'(idx) <= HALF);
   assign band_sel = band_index(int'(idx), BPB);

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_source_full) state_nxt = READ;
         READ: begin
            if (last_bin)            state_nxt = UPDATE;
            else if (i_source_empty) state_nxt = IDLE;
            else                     state_nxt = GAP;
         end
         GAP:     state_nxt = i_source_empty ? IDLE : READ;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- peak and level math ----------------
   // peak_nxt includes the bin being read this cycle, so the level update can
   // be taken on the edge that leaves the last READ.
   always_comb begin
      for (int b = 0; b < BANDS; b++) begin
         peak_nxt[b] = peak[b];
         if ((state == READ) && in_range && (band_sel == b) && (mag > peak[b]))
            peak_nxt[b] = mag;
         decayed[b] = (o_levels[b*MAG_W +: MAG_W] > MAG_W'(DECAY))
                    ? o_levels[b*MAG_W +: MAG_W] - MAG_W'(DECAY)
                    : '0;
         level_new[b] = (peak_nxt[b] > decayed[b]) ? peak_nxt[b] : decayed[b];
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx             <= '0;
         o_source_strobe <= 1'b0;
         o_busy          <= 1'b0;
         o_valid         <= 1'b0;
         o_levels        <= '0;
         for (int b = 0; b < BANDS; b++) peak[b] <= '0;
      end else begin
         // Strobe and busy are registered from the next state so they line up
         // exactly with the READ / non-IDLE cycles.
         o_source_strobe <= (state_nxt == READ);
         o_busy          <= (state_nxt != IDLE);
         o_valid         <= (state == READ) && last_bin;

         if (state == IDLE)     idx <= '0;
         else if (state == GAP) idx <= idx + IDX_W'(1);

         for (int b = 0; b < BANDS; b++)
            peak[b] <= (state == IDLE) ? '0 : peak_nxt[b];

         if ((state == READ) && last_bin)
            for (int b = 0; b < BANDS; b++)
               o_levels[b*MAG_W +: MAG_W] <= level_new[b];
      end
   end

endmodule

// File: tb/tb_spectrum_bands.sv
module tb_spectrum_bands;

   localparam int WIDTH   = 8;
   localparam int SAMPLES = 128;
   localparam int BANDS   = 8;
   localparam int DECAY   = 4;
   localparam int MAG_W   = WIDTH + 1;
   localparam int LW      = BANDS * MAG_W;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    re_in = '0;
   logic [7:0]    im_in = '0;
   logic          full  = 1'b0;
   logic          empty = 1'b0;
   logic          strobe;
   logic [LW-1:0] levels;
   logic          valid;
   logic          busy;

   always #5 clk = ~clk;

   spectrum_bands #(
      .WIDTH(WIDTH), .SAMPLES(SAMPLES), .BANDS(BANDS), .DECAY(DECAY)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_source_real   (re_in),
      .i_source_cplx   (im_in),
      .i_source_full   (full),
      .i_source_empty  (empty),
      .o_source_strobe (strobe),
      .o_levels        (levels),
      .o_valid         (valid),
      .o_busy          (busy)
   );

   int nvec = 0;
   int nerr = 0;
   int fr_re [SAMPLES];
   int fr_im [SAMPLES];
   int lvl_m [BANDS];

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int mag_of(input int re, input int im);
      int a, b;
      a = (re < 0) ? -re : re;
      b = (im < 0) ? -im : im;
      return (a > b) ? a + b / 2 : b + a / 2;
   endfunction

   task automatic model_frame();
      int pk [BANDS];
      for (int b = 0; b < BANDS; b++) pk[b] = 0;
      for (int k = 1; k <= SAMPLES / 2; k++) begin
         int bb, m;
         bb = (k - 1) / (SAMPLES / (2 * BANDS));
         m  = mag_of(fr_re[k], fr_im[k]);
         if (m > pk[bb]) pk[bb] = m;
      end
      for (int b = 0; b < BANDS; b++) begin
         int d;
         d = (lvl_m[b] > DECAY) ? lvl_m[b] - DECAY : 0;
         lvl_m[b] = (pk[b] > d) ? pk[b] : d;
      end
   endtask

   function automatic logic [LW-1:0] model_levels();
      logic [LW-1:0] r;
      r = '0;
      for (int b = 0; b < BANDS; b++) r[b*MAG_W +: MAG_W] = MAG_W'(lvl_m[b]);
      return r;
   endfunction

   task automatic clear_frame();
      for (int k = 0; k < SAMPLES; k++) begin
         fr_re[k] = 0;
         fr_im[k] = 0;
      end
   endtask

   task automatic random_frame();
      for (int k = 0; k < SAMPLES; k++) begin
         fr_re[k] = int'($urandom_range(255, 0)) - 128;
         fr_im[k] = int'($urandom_range(255, 0)) - 128;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      full  = 1'b0;
      empty = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int b = 0; b < BANDS; b++) lvl_m[b] = 0;
   endtask

   // Plays the FFT output buffer: presents bin rp, advances after each strobe.
   // stop_bin >= 0 either drains the buffer early or pulses reset at that bin.
   task automatic run_frame(input int stop_bin, input bit use_reset,
                            output int strobes, output int vals,
                            output int t0, output int tv);
      int rp, stop_t;
      bit prev, stopped;
      rp = 0; strobes = 0; vals = 0; t0 = -1; tv = -1;
      prev = 1'b0; stopped = 1'b0; stop_t = 0;
      re_in = 8'(fr_re[0]);
      im_in = 8'(fr_im[0]);
      empty = 1'b0;
      full  = 1'b1;
      for (int t = 0; t < 600; t++) begin
         @(posedge clk);
         #1;
         if (prev) begin
            rp++;
            if (rp < SAMPLES) begin
               re_in = 8'(fr_re[rp]);
               im_in = 8'(fr_im[rp]);
            end else begin
               empty = 1'b1;
            end
         end
         if (strobe) begin
            strobes++;
            if (t0 < 0) t0 = t;
            full = 1'b0;
         end
         if (valid) begin
            vals++;
            tv = t;
         end
         if (t0 >= 0 && t == t0 + 20) chk("busy_mid_frame", LW'(busy), LW'(1));
         prev = strobe;
         if (stop_bin >= 0 && !stopped && rp == stop_bin) begin
            stopped = 1'b1;
            stop_t  = t;
            full    = 1'b0;
            if (use_reset) begin
               rst_n = 1'b0;
               #1;
               chk("reset_levels", levels, '0);
               chk("reset_ctl", LW'({valid, strobe, busy}), '0);
               for (int b = 0; b < BANDS; b++) lvl_m[b] = 0;
               @(posedge clk);
               #1 rst_n = 1'b1;
               break;
            end else begin
               empty = 1'b1;
            end
         end
         if (vals > 0 && t >= tv + 1) break;
         if (stopped && t >= stop_t + 8) break;
      end
   endtask

   task automatic full_frame(input string tag);
      int s, v, t0, tv;
      run_frame(-1, 1'b0, s, v, t0, tv);
      model_frame();
      chk({tag, "_strobes"}, LW'(s), LW'(SAMPLES));
      chk({tag, "_valid_pulses"}, LW'(v), LW'(1));
      chk({tag, "_detect"}, LW'(t0), LW'(0));
      chk({tag, "_latency"}, LW'(tv - t0), LW'(2 * SAMPLES - 1));
      chk({tag, "_levels"}, levels, model_levels());
      chk({tag, "_idle_busy"}, LW'(busy), LW'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, v, t0, tv, e7;
      for (int b = 0; b < BANDS; b++) lvl_m[b] = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("por_levels", levels, '0);
      chk("por_ctl", LW'({valid, strobe, busy}), '0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_no_strobe", LW'({strobe, busy}), '0);

      // Single tone in band 0
      clear_frame();
      fr_re[5] = 100;
      full_frame("tone_b0");
      chk("tone_b0_value", LW'(levels[0 +: MAG_W]), LW'(100));

      // Most negative components: abs edge case, band 1
      do_reset();
      clear_frame();
      fr_re[9] = -128;
      fr_im[9] = -128;
      full_frame("neg_b1");
      chk("neg_b1_value", LW'(levels[MAG_W +: MAG_W]), LW'(192));
      chk("neg_b0_value", LW'(levels[0 +: MAG_W]), LW'(0));

      // DC and mirror bins discarded
      do_reset();
      clear_frame();
      fr_re[0] = 127; fr_im[0] = 127;
      fr_re[100] = 127;
      full_frame("dc_mirror");
      chk("dc_mirror_zero", levels, '0);

      // Top band then decay to floor
      do_reset();
      clear_frame();
      fr_re[64] = 40; fr_im[64] = 30;
      full_frame("top_b7");
      chk("top_b7_value", LW'(levels[7*MAG_W +: MAG_W]), LW'(55));
      for (int f = 1; f <= 20; f++) begin
         clear_frame();
         full_frame("decay");
         e7 = (55 - DECAY * f > 0) ? 55 - DECAY * f : 0;
         chk("decay_b7", LW'(levels[7*MAG_W +: MAG_W]), LW'(e7));
      end

      // Random frames against the model
      for (int n = 0; n < 5; n++) begin
         random_frame();
         full_frame("random");
      end

      // Source drains early: frame abandoned, levels held
      random_frame();
      run_frame(30, 1'b0, s, v, t0, tv);
      chk("abort_strobes", LW'(s), LW'(30));
      chk("abort_no_valid", LW'(v), LW'(0));
      chk("abort_levels", levels, model_levels());
      chk("abort_idle", LW'({busy, strobe}), '0);
      random_frame();
      full_frame("after_abort");

      // Reset mid-frame, then a clean frame
      random_frame();
      run_frame(60, 1'b1, s, v, t0, tv);
      chk("rst_mid_no_valid", LW'(v), LW'(0));
      clear_frame();
      fr_re[1] = 10;
      full_frame("after_reset");
      chk("after_reset_b0", LW'(levels[0 +: MAG_W]), LW'(10));

      // Random sparse frames to exercise peak vs decay interplay
      for (int n = 0; n < 4; n++) begin
         clear_frame();
         for (int j = 0; j < 6; j++) begin
            int k;
            k = int'($urandom_range(SAMPLES - 1, 0));
            fr_re[k] = int'($urandom_range(255, 0)) - 128;
            fr_im[k] = int'($urandom_range(255, 0)) - 128;
         end
         full_frame("sparse");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/spectrum_bands.md
# spectrum_bands

Downstream consumer of the FFT block's output buffer. It drains one complete frame of SAMPLES complex bins through the source-side strobe interface and computes an alpha-max-plus-beta-min magnitude per bin. It folds bins 1..SAMPLES/2 into BANDS linear bands (peak per band), applies per-band falling-bar decay, and presents registered band levels to the display driver with a one-cycle valid pulse.

## Interface
- WIDTH, 8: bit width of each signed real/imag component from the FFT.
- SAMPLES, 128: bins per frame; power of two, ≥ 2·BANDS.
- BANDS, 8: number of output bands; power of two, divides SAMPLES/2.
- DECAY, 4: amount subtracted from a displayed level per frame when no new peak exceeds it.
- Derived: MAG_W = WIDTH+1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_source_real  in  WIDTH  FFT bin real part, two's complement.
- i_source_cplx  in  WIDTH  FFT bin imaginary part, two's complement.
- i_source_full  in  1  FFT output buffer holds a complete unread frame.
- i_source_empty  in  1  FFT output buffer fully drained.
- o_source_strobe  out  1  advance FFT read pointer by one bin.
- o_levels  out  BANDS·MAG_W  band levels; band b at bits [b·MAG_W +: MAG_W], band 0 = lowest frequency.
- o_valid  out  1  one-cycle pulse when o_levels has been updated.
- o_busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, READ, GAP, UPDATE.
- IDLE: clear per-band peak accumulators and bin index. Go to READ when i_source_full=1.
- READ: capture i_source_real/i_source_cplx for bin idx in this cycle, assert o_source_strobe for exactly this cycle, then go to GAP. If idx = SAMPLES−1, go to UPDATE instead.
- GAP: strobe low and idx += 1. Gives the source RAM one full cycle to present the next bin. Then go to READ.
- Magnitude: a = |re|, b = |im|, both unsigned WIDTH bits (|−2^(WIDTH−1)| = 2^(WIDTH−1) is exact). mag = max(a,b) + (min(a,b) >> 1) in MAG_W bits. No overflow: the maximum is 2^(WIDTH−1)·1.5.
- Band mapping: bin k with 1 ≤ k ≤ SAMPLES/2 goes to band (k−1) / (SAMPLES/(2·BANDS)). Bin 0 (DC) and bins > SAMPLES/2 (mirror) are read and discarded.
- Accumulation: peak[band] = max(peak[band], mag).
- UPDATE (one cycle): for every band in parallel, level_new = max(peak, sat0(level_old − DECAY)), where sat0 floors at 0. Register level_new into o_levels, pulse o_valid, return to IDLE.
- Abort: if i_source_empty=1 in READ or GAP before idx = SAMPLES−1, return to IDLE. o_levels is unchanged and there is no o_valid pulse.
- Reset: o_levels = 0, o_valid = 0, o_source_strobe = 0, o_busy = 0, state = IDLE, idx = 0, peaks = 0. Reset asserted mid-frame discards the partial frame. After release, the block waits for the next i_source_full.

## Timing
- Strobe cadence: one pulse every 2 cycles. A frame read takes 2·SAMPLES−1 cycles from the first READ.
- Detection: READ is entered the cycle after i_source_full is sampled high.
- Latency: o_valid rises the cycle after the READ of bin SAMPLES−1. o_levels changes on the same edge that raises o_valid.
- i_source_full is ignored outside IDLE. A frame completing while already in IDLE after UPDATE starts immediately: at most one idle cycle between frames.
- o_source_strobe is never asserted in IDLE or UPDATE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package vu_pkg holds:
  - state encoding constants (IDLE, READ, GAP, UPDATE);
  - MAG_W derivation;
  - the bins-per-band constant;
  - the band-index computation as a function.
- Sub-module cplx_mag: combinational abs/max/min/shift-add (WIDTH in, MAG_W out), instantiated once. It is reused by the later level-meter path.
- Peak accumulators: BANDS × MAG_W registers. Output levels: a separate BANDS × MAG_W register bank.

## Test plan
- Bin 5 = (re 100, im 0), all other bins zero, from reset → after 2·128−1 cycles o_valid pulses once; band 0 = 100, other bands 0; exactly 128 strobes counted.
- Bin 9 = (−128, −128) → mag = 128 + 64 = 192; band 1 = 192, band 0 = 0 (checks sign and abs edge case).
- Bin 0 = (127, 127) and bin 100 = (127, 0) → all bands 0 (DC and mirror discarded).
- Bin 64 = (40, 30) → mag = 40 + 15 = 55 in band 7. Then 20 all-zero frames → band 7 reads 51, 47, …, 3, 0, and stays 0 from frame 15 on (decay floor).
- Frame in progress, deassert i_rst_n at bin 60 → all outputs 0 immediately. Next full frame with bin 1 = (10, 0) → band 0 = 10.
- Drive i_source_empty high at bin 30 → return to IDLE, no o_valid pulse, o_levels unchanged from the prior frame.
